// File: rtl/replay_drain_if.sv
// Handshake bundle between the replay pipe output stage, the drain buffer
// and its consumer. The drain buffer takes the slave view.
interface replay_drain_if #(
  parameter int W     = 32,
  parameter int DEPTH = 16
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic [W-1:0]  in;
  logic          in_vld;
  logic [W-1:0]  out_r;
  logic          out_vld_r;
  logic          out_accept;
  logic          stall_r;
  logic          ovf_r;
  logic [OW-1:0] occ_r;

  modport slave (
    input  in, in_vld, out_accept,
    output out_r, out_vld_r, stall_r, ovf_r, occ_r
  );

  modport master (
    output in, in_vld, out_accept,
    input  out_r, out_vld_r, stall_r, ovf_r, occ_r
  );
endinterface

// File: rtl/replay_drain.sv
// Drain buffer for the non-stallable replay pipe output. Every valid word is
// captured into a FIFO and re-presented under valid/accept. A hysteretic,
// registered stall request throttles the pipe early enough that in-flight
// words still fit; words that cannot be stored set a sticky overflow flag.
module replay_drain #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int HI_WM = 6,
  parameter int LO_WM = 4
) (
  input logic           clk,
  input logic           rst,
  replay_drain_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] HI = (AW+1)'(HI_WM);
  localparam logic [AW:0] LO = (AW+1)'(LO_WM);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wrPtr;
  logic [AW:0]  r_rdPtr;
  logic [AW:0]  r_occ;
  logic         r_full;
  logic         r_empty;
  logic         r_ovf;
  logic [0:0]   r_state;

  logic         w_rd;
  logic         w_wr;
  logic         w_drop;
  logic [AW:0]  w_wrPtrNext;
  logic [AW:0]  w_rdPtrNext;
  logic [AW:0]  w_occNext;
  logic [0:0]   w_stateNext;

  // Handshake decode and next-state pointer/occupancy arithmetic. A write at
  // full is allowed when the head is leaving in the same cycle.
  always_comb begin
    w_rd        = ~r_empty & bus.out_accept;
    w_wr        = bus.in_vld & (~r_full | w_rd);
    w_drop      = bus.in_vld & r_full & ~w_rd;
    w_wrPtrNext = r_wrPtr + {{AW{1'b0}}, w_wr};
    w_rdPtrNext = r_rdPtr + {{AW{1'b0}}, w_rd};
    w_occNext   = r_occ + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
  end

  // Stall hysteresis: enter HOLD at the high watermark, leave below the low one.
  always_comb begin
    w_stateNext = r_state;
    if (r_state == S_RUN && w_occNext >= HI) begin
      w_stateNext = S_HOLD;
    end else if (r_state == S_HOLD && w_occNext < LO) begin
      w_stateNext = S_RUN;
    end
  end

  // Storage array; deliberately not reset, pointers alone define contents.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      r_mem[r_wrPtr[AW-1:0]] <= bus.in;
    end
  end

  // Pointers, flags, occupancy, sticky overflow and stall state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_state <= S_RUN;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      r_rdPtr <= w_rdPtrNext;
      r_occ   <= w_occNext;
      r_full  <= (w_wrPtrNext[AW] != w_rdPtrNext[AW]) &&
                 (w_wrPtrNext[AW-1:0] == w_rdPtrNext[AW-1:0]);
      r_empty <= (w_wrPtrNext == w_rdPtrNext);
      r_state <= w_stateNext;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.out_r     = r_mem[r_rdPtr[AW-1:0]];
  assign bus.out_vld_r = ~r_empty;
  assign bus.occ_r     = r_occ;
  assign bus.ovf_r     = r_ovf;
  assign bus.stall_r   = (r_state == S_HOLD);
endmodule

// File: tb/tb_replay_drain.sv
// Self-checking bench for replay_drain: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_replay_drain;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int HI_WM = 6;
  localparam int LO_WM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;
  bit cmpOn = 1'b0;

  logic [W-1:0] q [$];
  bit           modelOvf   = 1'b0;
  bit           modelStall = 1'b0;

  replay_drain_if #(.W(W), .DEPTH(DEPTH)) bus ();

  replay_drain #(.W(W), .DEPTH(DEPTH), .HI_WM(HI_WM), .LO_WM(LO_WM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs away from the active edge.
  task automatic applyStimulus(input bit vld, input logic [W-1:0] data, input bit acc);
    @(negedge clk);
    bus.in_vld     = vld;
    bus.in         = data;
    bus.out_accept = acc;
  endtask

  // Reference model: a FIFO queue with drop, sticky overflow and hysteresis.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      modelOvf   = 1'b0;
      modelStall = 1'b0;
    end else begin
      bit rd;
      bit full;
      rd   = (q.size() > 0) && bus.out_accept;
      full = (q.size() == DEPTH);
      if (rd) void'(q.pop_front());
      if (bus.in_vld) begin
        if (!full || rd) q.push_back(bus.in);
        else modelOvf = 1'b1;
      end
      if (!modelStall && q.size() >= HI_WM) modelStall = 1'b1;
      else if (modelStall && q.size() < LO_WM) modelStall = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("occ", W'(bus.occ_r), W'(q.size()));
      checkOutput("out_vld", W'(bus.out_vld_r), W'(q.size() > 0));
      checkOutput("stall", W'(bus.stall_r), W'(modelStall));
      checkOutput("ovf", W'(bus.ovf_r), W'(modelOvf));
      if (q.size() > 0) checkOutput("out_data", bus.out_r, q[0]);
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst            = 1'b1;
    bus.in_vld     = 1'b1;
    bus.in         = 32'hDEAD;
    bus.out_accept = 1'b0;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    bus.in_vld = 1'b0;
  endtask

  initial begin
    bus.in         = '0;
    bus.in_vld     = 1'b0;
    bus.out_accept = 1'b0;

    // Reset with in_vld high must leave everything cleared.
    doReset();
    cmpOn = 1'b1;
    checkOutput("rst_vld", W'(bus.out_vld_r), 0);
    checkOutput("rst_stall", W'(bus.stall_r), 0);
    checkOutput("rst_ovf", W'(bus.ovf_r), 0);
    checkOutput("rst_occ", W'(bus.occ_r), 0);

    // Latency and ordering with continuous accept.
    applyStimulus(1, 32'hA1, 1);
    checkOutput("lat_vld_pre", W'(bus.out_vld_r), 0);
    applyStimulus(1, 32'hA2, 1);
    checkOutput("lat_vld", W'(bus.out_vld_r), 1);
    checkOutput("lat_d1", bus.out_r, 32'hA1);
    checkOutput("lat_occ1", W'(bus.occ_r), 1);
    applyStimulus(1, 32'hA3, 1);
    checkOutput("lat_d2", bus.out_r, 32'hA2);
    checkOutput("lat_occ2", W'(bus.occ_r), 1);
    applyStimulus(0, 0, 1);
    checkOutput("lat_d3", bus.out_r, 32'hA3);
    checkOutput("lat_occ3", W'(bus.occ_r), 1);
    applyStimulus(0, 0, 1);
    checkOutput("lat_empty", W'(bus.out_vld_r), 0);

    // Watermark hysteresis.
    for (int i = 0; i < 6; i++) applyStimulus(1, 32'h100 + i, 0);
    checkOutput("hys_pre", W'(bus.stall_r), 0);
    applyStimulus(0, 0, 1);
    checkOutput("hys_on", W'(bus.stall_r), 1);
    checkOutput("hys_occ6", W'(bus.occ_r), 6);
    applyStimulus(0, 0, 1);
    checkOutput("hys_occ5", W'(bus.stall_r), 1);
    applyStimulus(0, 0, 1);
    checkOutput("hys_occ4", W'(bus.stall_r), 1);
    applyStimulus(0, 0, 1);
    checkOutput("hys_occ3_cnt", W'(bus.occ_r), 3);
    checkOutput("hys_off", W'(bus.stall_r), 0);
    repeat (4) applyStimulus(0, 0, 1);
    checkOutput("hys_drained", W'(bus.occ_r), 0);

    // Overflow: 17 writes into a 16-deep FIFO with no accept.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, W'(i), 0);
      if (i == 16) checkOutput("ovf_pre", W'(bus.ovf_r), 0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("ovf_occ", W'(bus.occ_r), 16);
    checkOutput("ovf_vld", W'(bus.out_vld_r), 1);
    checkOutput("ovf_set", W'(bus.ovf_r), 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput("ovf_drain", bus.out_r, W'(i));
    end
    applyStimulus(0, 0, 0);
    checkOutput("ovf_empty", W'(bus.out_vld_r), 0);
    checkOutput("ovf_sticky", W'(bus.ovf_r), 1);

    // Full with simultaneous read and write.
    doReset();
    checkOutput("rst_ovf_clr", W'(bus.ovf_r), 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 32'h200 + i, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'h300 + i, 1);
      checkOutput("full_occ", W'(bus.occ_r), 16);
      checkOutput("full_ovf", W'(bus.ovf_r), 0);
    end
    applyStimulus(0, 0, 1);
    checkOutput("full_head", bus.out_r, 32'h304);
    repeat (16) applyStimulus(0, 0, 1);

    // Random traffic exercising pointer wrap.
    doReset();
    for (int i = 0; i < 100; i++) begin
      applyStimulus($urandom_range(0, 9) < 5, $urandom, $urandom_range(0, 9) < 7);
    end
    applyStimulus(0, 0, 0);
    checkOutput("rand_ovf", W'(bus.ovf_r), 0);
    repeat (20) applyStimulus(0, 0, 1);
    checkOutput("rand_empty", W'(bus.out_vld_r), 0);

    @(negedge clk);
    cmpOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
